mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  input  1  core clock; all state SHALL update on its rising edge.
REQ-002 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-003 in_valid  input  1  execute-stage result valid this cycle.
REQ-004 ctrl_memread / ctrl_memwrite  input  1 each  load / store request from control.
REQ-005 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 alu_result  input  32  effective byte address from execute.
REQ-007 rdata2  input  32  store data.
REQ-008 dbus_req, dbus_we  output  1 each  data-bus request and write strobe.
REQ-009 dbus_addr  output  32  word address, bits [1:0] forced to 00.
REQ-010 dbus_be  output  4  byte enables; dbus_wdata  output  32  lane-aligned store data.
REQ-011 dbus_gnt  input  1  request accepted; dbus_rvalid  input  1  read data valid; dbus_rdata  input  32.
REQ-012 stall  output  1  holds the upstream pipeline.
REQ-013 mem_done  output  1  one-cycle completion pulse; mem_rdata  output  32  extended load result.
REQ-014 mem_misalign  output  1  one-cycle error pulse.

Function
REQ-015 FSM states IDLE, REQ, WAIT, DONE; encoding 2 bits.
REQ-016 IDLE: in_valid with memread or memwrite SHALL capture addr, data, funct3, op and go to REQ; if both set, the access SHALL be a load; in_valid with neither SHALL be ignored with no stall.
REQ-017 Misaligned (H with addr[0]=1, W with addr[1:0]!=0) or an unsupported funct3 SHALL skip the bus, go to DONE, and pulse mem_misalign with mem_done.
REQ-018 REQ: dbus_req=1 with stable addr/we/be/wdata until dbus_gnt; on gnt a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-019 WAIT: on dbus_rvalid SHALL register the extended dbus_rdata into mem_rdata and go to DONE.
REQ-020 DONE: mem_done=1 for exactly one cycle, then IDLE.
REQ-021 stall = (IDLE and in_valid and mem op) or state in {REQ, WAIT}; it SHALL be low in DONE.
REQ-022 in_valid SHALL be ignored outside IDLE.
REQ-023 Byte enables: B -> 0001<<addr[1:0]; H -> 0011 or 1100 per addr[1]; W -> 1111.
REQ-024 Store data: B replicated to all four lanes, H replicated to both halves, W unchanged.
REQ-025 Load data: select the lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend to 32.
REQ-026 mem_rdata SHALL hold until the next completed load.
REQ-027 Minimum latency with gnt and rvalid in the same cycle as asserted: store done at N+2 and load done at N+3, where N is the in_valid cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, with dbus_req=0, dbus_we=0, dbus_be=0, dbus_addr=0, dbus_wdata=0, stall=0, mem_done=0, mem_misalign=0 and mem_rdata=0, including mid-transaction.

Structure
REQ-029 funct3 size codes and FSM state encodings SHALL live in the shared core defines header.
REQ-030 Lane selection, extension and byte-enable logic SHALL be one combinational sub-module, lsu_align.

Verification
REQ-031 SW: addr 0x100, data 0xDEADBEEF, gnt on the first REQ cycle -> be=1111, addr=0x100, we=1, mem_done at N+2.
REQ-032 LB: addr 0x203, rdata 0x80FF_FF_FF -> be=1000, mem_rdata=0xFFFFFF80; LBU with the same values -> 0x00000080.
REQ-033 SH: addr 0x12, data 0x0000ABCD -> be=1100, wdata=0xABCDABCD; LHU addr 0x12, rdata 0xABCD1234 -> 0x0000ABCD.
REQ-034 LW: addr 0x102 -> no dbus_req, mem_misalign and mem_done pulse together, stall high for one cycle only.
REQ-035 LW with gnt held off 3 cycles and rvalid 2 cycles later -> dbus_req and signals stable throughout, stall continuous, mem_done once.
REQ-036 rst_n dropped in WAIT -> same-cycle dbus_req=0 and stall=0; after release, a new SW completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared load/store definitions: funct3 access-size codes, FSM state encoding,
// and the alignment/legality check used when a request is accepted.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Unsigned sizes only exist for loads; a store with BU/HU is rejected.
  function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] a,
                                      input logic is_load);
    case (f3)
      F3_B:    return 1'b0;
      F3_H:    return a[0];
      F3_W:    return a != 2'b00;
      F3_BU:   return !is_load;
      F3_HU:   return !is_load || a[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-lane selection with sign/zero extension.
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = ld_data[7:0];
      2'd1:    lane_b = ld_data[15:8];
      2'd2:    lane_b = ld_data[23:16];
      default: lane_b = ld_data[31:24];
    endcase
    lane_h = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

    be     = 4'b0000;
    wdata  = st_data;
    ld_ext = ld_data;
    // funct3[2] distinguishes the zero-extending variants
    case (funct3)
      F3_B, F3_BU: begin
        be     = 4'b0001 << addr_lo;
        wdata  = {4{st_data[7:0]}};
        ld_ext = funct3[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      F3_H, F3_HU: begin
        be     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{st_data[15:0]}};
        ld_ext = funct3[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      F3_W:    be = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: captures one load/store from execute, runs it over a
// req/gnt/rvalid data bus and returns the extended load result.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        ctrl_memread,
  input  logic        ctrl_memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mem_misalign
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        load_q, load_d;
  logic        bad_q, bad_d;
  logic        mem_op;
  logic [3:0]  be_al;
  logic [31:0] wdata_al;
  logic [31:0] ld_ext;

  assign mem_op = ctrl_memread | ctrl_memwrite;

  lsu_align u_align (
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .st_data (data_q),
    .ld_data (dbus_rdata),
    .be      (be_al),
    .wdata   (wdata_al),
    .ld_ext  (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    load_d  = load_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && mem_op) begin
          addr_d  = alu_result;
          data_d  = rdata2;
          f3_d    = funct3;
          load_d  = ctrl_memread;
          bad_d   = access_bad(funct3, alu_result[1:0], ctrl_memread);
          // Illegal accesses never touch the bus; they report straight away.
          state_d = bad_d ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (dbus_gnt) state_d = load_q ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (dbus_rvalid) begin
          rdata_d = ld_ext;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      load_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      bad_q   <= bad_d;
    end
  end

  assign dbus_req     = (state_q == S_REQ);
  assign dbus_we      = dbus_req && !load_q;
  assign dbus_be      = dbus_req ? be_al : 4'b0000;
  assign dbus_addr    = {addr_q[31:2], 2'b00};
  assign dbus_wdata   = wdata_al;
  // The IDLE term is combinational on inputs, so mask it while reset is held.
  assign stall        = rst_n && (((state_q == S_IDLE) && in_valid && mem_op) ||
                                  (state_q == S_REQ) || (state_q == S_WAIT));
  assign mem_done     = (state_q == S_DONE);
  assign mem_misalign = mem_done && bad_q;
  assign mem_rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a reactive bus responder drives gnt/rvalid,
// expected results come from an independent reference model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, ctrl_memread = 1'b0, ctrl_memwrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] alu_result = '0, rdata2 = '0;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        stall, mem_done, mem_misalign;
  logic [31:0] mem_rdata;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .ctrl_memread(ctrl_memread), .ctrl_memwrite(ctrl_memwrite),
    .funct3(funct3), .alu_result(alu_result), .rdata2(rdata2),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .stall(stall),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_misalign(mem_misalign)
  );

  typedef struct {
    logic rd; logic wr; logic [2:0] f3; logic [31:0] addr; logic [31:0] data;
    logic [31:0] rresp; int gnt_dly; int rv_dly; bit hold;
  } stim_t;

  typedef struct {
    int done_cyc; logic misalign; logic req; logic [31:0] addr; logic [3:0] be;
    logic we; logic [31:0] wdata; logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int done_cyc; logic misalign; logic req_seen; logic [31:0] addr; logic [3:0] be;
    logic we; logic [31:0] wdata; logic [31:0] rdata; int unstable; int stall_gaps;
    logic stall_n; logic stall_done; int extra_done;
  } obs_t;

  exp_t        sb[$];
  logic [31:0] mdl_rdata = '0;

  // ---------------- reference model ----------------
  function automatic bit m_bad(stim_t s);
    case (s.f3)
      3'b000:  return 0;
      3'b001:  return s.addr[0];
      3'b010:  return s.addr[1:0] != 2'b00;
      3'b100:  return !s.rd;
      3'b101:  return !s.rd || s.addr[0];
      default: return 1;
    endcase
  endfunction

  function automatic int m_size(logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic exp_t model(stim_t s, logic [31:0] prev);
    exp_t e;
    logic [31:0] sh;
    int sz;
    bit bad;
    bad = m_bad(s);
    sz = m_size(s.f3);
    sh = s.rresp >> (8 * s.addr[1:0]);
    e.misalign = bad;
    e.req = !bad;
    e.addr = s.addr & 32'hFFFF_FFFC;
    e.be = 4'(((1 << sz) - 1) << s.addr[1:0]);
    e.we = !s.rd;
    e.wdata = (sz == 1) ? s.data[7:0] * 32'h0101_0101 :
              (sz == 2) ? s.data[15:0] * 32'h0001_0001 : s.data;
    e.rdata = prev;
    if (s.rd && !bad) begin
      if (sz == 1) e.rdata = s.f3[2] ? {24'h0, sh[7:0]} : 32'($signed(sh[7:0]));
      else if (sz == 2) e.rdata = s.f3[2] ? {16'h0, sh[15:0]} : 32'($signed(sh[15:0]));
      else e.rdata = s.rresp;
    end
    e.done_cyc = bad ? 1 : s.rd ? 3 + s.gnt_dly + s.rv_dly : 2 + s.gnt_dly;
    return e;
  endfunction

  // Drives one access and answers the bus; observations only, no judging.
  task automatic run_access(input stim_t s, output obs_t o);
    int req_cnt, wait_cnt;
    bit granted;
    o = '{default: 0};
    req_cnt = 0; wait_cnt = 0; granted = 0;
    sb.push_back(model(s, mdl_rdata));
    in_valid = 1'b1; ctrl_memread = s.rd; ctrl_memwrite = s.wr;
    funct3 = s.f3; alu_result = s.addr; rdata2 = s.data;
    #1 o.stall_n = stall;
    @(posedge clk); #1;
    if (!s.hold) in_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
      if (dbus_req) begin
        if (!o.req_seen) begin
          o.req_seen = 1; o.addr = dbus_addr; o.be = dbus_be; o.we = dbus_we; o.wdata = dbus_wdata;
        end else if ({dbus_addr, dbus_be, dbus_we, dbus_wdata} !== {o.addr, o.be, o.we, o.wdata})
          o.unstable++;
        req_cnt++;
        if (req_cnt > s.gnt_dly) begin dbus_gnt = 1'b1; granted = 1; end
      end else if (granted && stall) begin
        wait_cnt++;
        dbus_rvalid = (wait_cnt > s.rv_dly);
        dbus_rdata = dbus_rvalid ? s.rresp : $urandom;
      end
      if (mem_done) begin
        o.done_cyc = c; o.misalign = mem_misalign; o.rdata = mem_rdata; o.stall_done = stall;
        in_valid = 1'b0;
        break;
      end
      if (!stall) o.stall_gaps++;
      if (s.hold) begin alu_result = $urandom; rdata2 = $urandom; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    ctrl_memread = 1'b0; ctrl_memwrite = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (mem_done) o.extra_done++;
    end
  endtask

  function automatic stim_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] data, logic [31:0] rresp, int gd, int rv);
    stim_t s;
    s.rd = rd; s.wr = wr; s.f3 = f3; s.addr = addr; s.data = data; s.rresp = rresp;
    s.gnt_dly = gd; s.rv_dly = rv; s.hold = 0;
    return s;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 rst_n = 1'b0;
    in_valid = 1'b1; ctrl_memread = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL rst_stall got %b want 0", stall); end
    nvec++; if ({dbus_req, dbus_we, dbus_be} !== 6'b0) begin nerr++;
      $display("FAIL rst_bus_ctl got %b%b%b want 000000", dbus_req, dbus_we, dbus_be); end
    nvec++; if ({dbus_addr, dbus_wdata} !== 64'h0) begin nerr++;
      $display("FAIL rst_bus_data got %h/%h want 0/0", dbus_addr, dbus_wdata); end
    nvec++; if ({mem_done, mem_misalign} !== 2'b00) begin nerr++;
      $display("FAIL rst_done got %b%b want 00", mem_done, mem_misalign); end
    nvec++; if (mem_rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata got %h want 0", mem_rdata); end
    in_valid = 1'b0; ctrl_memread = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore;
    in_valid = 1'b1; ctrl_memread = 1'b0; ctrl_memwrite = 1'b0; alu_result = 32'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if ({stall, dbus_req, mem_done} !== 3'b000) begin nerr++;
        $display("FAIL ignore[%0d] stall/req/done got %b%b%b want 000", i, stall, dbus_req, mem_done); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stores;
    stim_t t[4];
    obs_t o; exp_t e;
    t[0] = mk(0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 0);
    t[1] = mk(0, 1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 0, 0, 0);
    t[2] = mk(0, 1, 3'b000, 32'h0000_0201, 32'h1234_565A, 0, 1, 0);
    t[3] = mk(0, 1, 3'b001, 32'h8000_0010, 32'hFFFF_7E01, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_access(t[i], o);
      e = sb.pop_front(); mdl_rdata = e.rdata;
      nvec++; if (o.done_cyc !== e.done_cyc) begin nerr++;
        $display("FAIL st_latency[%0d] got %0d want %0d", i, o.done_cyc, e.done_cyc); end
      nvec++; if ({o.req_seen, o.we, o.be} !== {e.req, e.we, e.be}) begin nerr++;
        $display("FAIL st_req_we_be[%0d] got %b%b%b want %b%b%b", i, o.req_seen, o.we, o.be, e.req, e.we, e.be); end
      nvec++; if (o.addr !== e.addr) begin nerr++;
        $display("FAIL st_addr[%0d] got %h want %h", i, o.addr, e.addr); end
      nvec++; if (o.wdata !== e.wdata) begin nerr++;
        $display("FAIL st_wdata[%0d] got %h want %h", i, o.wdata, e.wdata); end
      nvec++; if (o.rdata !== e.rdata) begin nerr++;
        $display("FAIL st_rdata_hold[%0d] got %h want %h", i, o.rdata, e.rdata); end
    end
  endtask

  task automatic test_loads;
    stim_t t[6];
    obs_t o; exp_t e;
    t[0] = mk(1, 0, 3'b000, 32'h0000_0203, 0, 32'h80FF_FFFF, 0, 0);
    t[1] = mk(1, 0, 3'b100, 32'h0000_0203, 0, 32'h80FF_FFFF, 0, 0);
    t[2] = mk(1, 0, 3'b101, 32'h0000_0012, 0, 32'hABCD_1234, 0, 0);
    t[3] = mk(1, 0, 3'b001, 32'h0000_0010, 0, 32'h1234_8001, 1, 0);
    t[4] = mk(1, 0, 3'b010, 32'h0000_0104, 0, 32'hCAFE_F00D, 0, 1);
    t[5] = mk(1, 1, 3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_9900, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_access(t[i], o);
      e = sb.pop_front(); mdl_rdata = e.rdata;
      nvec++; if (o.done_cyc !== e.done_cyc) begin nerr++;
        $display("FAIL ld_latency[%0d] got %0d want %0d", i, o.done_cyc, e.done_cyc); end
      nvec++; if ({o.req_seen, o.we, o.be} !== {e.req, e.we, e.be}) begin nerr++;
        $display("FAIL ld_req_we_be[%0d] got %b%b%b want %b%b%b", i, o.req_seen, o.we, o.be, e.req, e.we, e.be); end
      nvec++; if (o.rdata !== e.rdata) begin nerr++;
        $display("FAIL ld_rdata[%0d] got %h want %h", i, o.rdata, e.rdata); end
      nvec++; if ({o.misalign, o.extra_done} !== {e.misalign, 32'd0}) begin nerr++;
        $display("FAIL ld_pulse[%0d] misalign %b extra_done %0d want %b 0", i, o.misalign, o.extra_done, e.misalign); end
    end
  endtask

  task automatic test_misalign;
    stim_t t[6];
    obs_t o; exp_t e;
    t[0] = mk(1, 0, 3'b010, 32'h0000_0102, 0, 32'h1111_1111, 0, 0);
    t[1] = mk(0, 1, 3'b001, 32'h0000_0013, 32'h5555_5555, 0, 0, 0);
    t[2] = mk(1, 0, 3'b001, 32'h0000_0011, 0, 32'h2222_2222, 0, 0);
    t[3] = mk(0, 1, 3'b010, 32'h0000_0101, 32'h6666_6666, 0, 0, 0);
    t[4] = mk(1, 0, 3'b011, 32'h0000_0100, 0, 32'h3333_3333, 0, 0);
    t[5] = mk(0, 1, 3'b100, 32'h0000_0100, 32'h7777_7777, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_access(t[i], o);
      e = sb.pop_front(); mdl_rdata = e.rdata;
      nvec++; if (o.done_cyc !== e.done_cyc) begin nerr++;
        $display("FAIL mis_latency[%0d] got %0d want %0d", i, o.done_cyc, e.done_cyc); end
      nvec++; if ({o.misalign, o.req_seen} !== {e.misalign, e.req}) begin nerr++;
        $display("FAIL mis_flag_req[%0d] got %b%b want %b%b", i, o.misalign, o.req_seen, e.misalign, e.req); end
      nvec++; if ({o.stall_n, o.stall_done} !== 2'b10) begin nerr++;
        $display("FAIL mis_stall[%0d] got N=%b done=%b want 1/0", i, o.stall_n, o.stall_done); end
      nvec++; if (o.rdata !== e.rdata) begin nerr++;
        $display("FAIL mis_rdata_hold[%0d] got %h want %h", i, o.rdata, e.rdata); end
    end
  endtask

  task automatic test_stall_gnt;
    stim_t t[2];
    obs_t o; exp_t e;
    t[0] = mk(1, 0, 3'b010, 32'h0000_0040, 0, 32'h0BAD_CAFE, 3, 2);
    t[1] = mk(0, 1, 3'b000, 32'h0000_0042, 32'h0000_00A5, 0, 2, 0);
    t[1].hold = 1;
    for (int i = 0; i < 2; i++) begin
      run_access(t[i], o);
      e = sb.pop_front(); mdl_rdata = e.rdata;
      nvec++; if (o.done_cyc !== e.done_cyc) begin nerr++;
        $display("FAIL slow_latency[%0d] got %0d want %0d", i, o.done_cyc, e.done_cyc); end
      nvec++; if (o.unstable !== 0) begin nerr++;
        $display("FAIL slow_stable[%0d] got %0d changes want 0", i, o.unstable); end
      nvec++; if ({o.stall_n, o.stall_gaps} !== {1'b1, 32'd0}) begin nerr++;
        $display("FAIL slow_stall[%0d] got N=%b gaps=%0d want 1/0", i, o.stall_n, o.stall_gaps); end
      nvec++; if (o.extra_done !== 0) begin nerr++;
        $display("FAIL slow_done_once[%0d] got %0d extra want 0", i, o.extra_done); end
      nvec++; if ({o.addr, o.be, o.rdata} !== {e.addr, e.be, e.rdata}) begin nerr++;
        $display("FAIL slow_data[%0d] got %h/%b/%h want %h/%b/%h", i, o.addr, o.be, o.rdata, e.addr, e.be, e.rdata); end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] f3s[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    stim_t s;
    obs_t o; exp_t e;
    for (int i = 0; i < 8; i++) begin
      s = mk($urandom_range(0, 1), 0, f3s[$urandom_range(0, 4)], $urandom & 32'h0000_FFFC,
             $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
      s.wr = !s.rd;
      if (!s.rd) s.f3[2] = 1'b0;
      if (s.f3[1:0] == 2'b00) s.addr[1:0] = 2'($urandom_range(0, 3));
      else if (s.f3[1:0] == 2'b01) s.addr[1] = 1'($urandom_range(0, 1));
      run_access(s, o);
      e = sb.pop_front(); mdl_rdata = e.rdata;
      nvec++; if (o.done_cyc !== e.done_cyc) begin nerr++;
        $display("FAIL b2b_latency[%0d] got %0d want %0d", i, o.done_cyc, e.done_cyc); end
      nvec++; if ({o.be, o.we} !== {e.be, e.we}) begin nerr++;
        $display("FAIL b2b_be_we[%0d] got %b%b want %b%b", i, o.be, o.we, e.be, e.we); end
      nvec++; if (o.rdata !== e.rdata) begin nerr++;
        $display("FAIL b2b_rdata[%0d] got %h want %h", i, o.rdata, e.rdata); end
      if (!s.rd) begin
        nvec++; if (o.wdata !== e.wdata) begin nerr++;
          $display("FAIL b2b_wdata[%0d] got %h want %h", i, o.wdata, e.wdata); end
      end
    end
  endtask

  task automatic test_reset_midflight;
    obs_t o; exp_t e;
    // Drop reset while the request is still waiting for a grant.
    in_valid = 1'b1; ctrl_memread = 1'b1; funct3 = 3'b010; alu_result = 32'h300;
    @(posedge clk); #1;
    in_valid = 1'b0; ctrl_memread = 1'b0;
    nvec++; if (dbus_req !== 1'b1) begin nerr++; $display("FAIL mid_req_up got %b want 1", dbus_req); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if ({dbus_req, stall, dbus_be} !== 6'b0) begin nerr++;
      $display("FAIL mid_req_rst got req=%b stall=%b be=%b want 0/0/0000", dbus_req, stall, dbus_be); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // Drop reset in WAIT.
    in_valid = 1'b1; ctrl_memread = 1'b1; funct3 = 3'b000; alu_result = 32'h301;
    @(posedge clk); #1;
    in_valid = 1'b0; ctrl_memread = 1'b0; dbus_gnt = 1'b1;
    @(posedge clk); #1;
    dbus_gnt = 1'b0;
    nvec++; if ({stall, dbus_req} !== 2'b10) begin nerr++;
      $display("FAIL mid_wait_up got stall=%b req=%b want 1/0", stall, dbus_req); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if ({dbus_req, stall, mem_done} !== 3'b000) begin nerr++;
      $display("FAIL mid_wait_rst got req=%b stall=%b done=%b want 000", dbus_req, stall, mem_done); end
    nvec++; if (mem_rdata !== 32'h0) begin nerr++; $display("FAIL mid_wait_rdata got %h want 0", mem_rdata); end
    mdl_rdata = '0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_access(mk(0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 0), o);
    e = sb.pop_front(); mdl_rdata = e.rdata;
    nvec++; if (o.done_cyc !== e.done_cyc) begin nerr++;
      $display("FAIL post_rst_latency got %0d want %0d", o.done_cyc, e.done_cyc); end
    nvec++; if ({o.addr, o.be, o.we, o.wdata} !== {e.addr, e.be, e.we, e.wdata}) begin nerr++;
      $display("FAIL post_rst_bus got %h/%b/%b/%h want %h/%b/%b/%h", o.addr, o.be, o.we, o.wdata,
               e.addr, e.be, e.we, e.wdata); end
  endtask

  initial begin
    test_reset();
    test_ignore();
    test_stores();
    test_loads();
    test_misalign();
    test_stall_gnt();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d vectors", nvec);
    $fatal(1);
  end

endmodule
